// File: rtl/operand_address_sequencer_pkg.sv
// Addressing-mode codes, FSM state encodings and bus-select codes
// shared by the operand address sequencer and its index adder.
package operand_address_sequencer_pkg;

  localparam logic [3:0] ADRM_IMPL  = 4'd0;
  localparam logic [3:0] ADRM_IMM   = 4'd1;
  localparam logic [3:0] ADRM_ZPG   = 4'd2;
  localparam logic [3:0] ADRM_ZPG_X = 4'd3;
  localparam logic [3:0] ADRM_ZPG_Y = 4'd4;
  localparam logic [3:0] ADRM_ABS   = 4'd5;
  localparam logic [3:0] ADRM_ABS_X = 4'd6;
  localparam logic [3:0] ADRM_ABS_Y = 4'd7;
  localparam logic [3:0] ADRM_IND_X = 4'd8;
  localparam logic [3:0] ADRM_IND_Y = 4'd9;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_OP_LO    = 4'd1;
  localparam logic [3:0] S_OP_HI    = 4'd2;
  localparam logic [3:0] S_CALC     = 4'd3;
  localparam logic [3:0] S_PTR_LO   = 4'd4;
  localparam logic [3:0] S_PTR_HI   = 4'd5;
  localparam logic [3:0] S_PTR_CALC = 4'd6;
  localparam logic [3:0] S_FIX      = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  localparam logic [1:0] ADSEL_PC  = 2'd0;
  localparam logic [1:0] ADSEL_BUS = 2'd1;

  function automatic logic is_abs(input logic [3:0] m);
    return (m == ADRM_ABS) || (m == ADRM_ABS_X) ||
           (m == ADRM_ABS_Y);
  endfunction

  function automatic logic is_zp(input logic [3:0] m);
    return (m == ADRM_ZPG_X) || (m == ADRM_ZPG_Y) ||
           (m == ADRM_IND_X) || (m == ADRM_IND_Y);
  endfunction

  function automatic logic uses_x(input logic [3:0] m);
    return (m == ADRM_ZPG_X) || (m == ADRM_ABS_X) ||
           (m == ADRM_IND_X);
  endfunction

  function automatic logic uses_y(input logic [3:0] m);
    return (m == ADRM_ZPG_Y) || (m == ADRM_ABS_Y);
  endfunction

endpackage

// File: rtl/operand_address_sequencer_ea_index_adder.sv
// ea_index_adder: 16-bit base + 8-bit index, optional zero-page wrap.
// Ports: base, idx, zp (wrap in page 0) -> sum, carry (low-byte carry).
module ea_index_adder
  import operand_address_sequencer_pkg::*;
(
  input  logic [15:0] base,
  input  logic [7:0]  idx,
  input  logic        zp,
  output logic [15:0] sum,
  output logic        carry
);

  logic [8:0] lo_sum;

  always_comb begin
    lo_sum = {1'b0, base[7:0]} + {1'b0, idx};
    if (zp) begin
      sum   = {8'h00, lo_sum[7:0]};
      carry = 1'b0;
    end else begin
      sum   = {base[15:8] + {7'd0, lo_sum[8]},
               lo_sum[7:0]};
      carry = lo_sum[8];
    end
  end

endmodule

// File: rtl/operand_address_sequencer.sv
// Multi-cycle operand fetch / effective-address sequencer.
// In: clk res(async low) rdy start mode data_in index_x index_y.
// Out: address_select bus_addr pc_enable busy ea ea_imm ea_valid
// page_cross err. Macro ADR_INDIRECT_EN builds modes 8/9.
module operand_address_sequencer
  import operand_address_sequencer_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int PAGE_PENALTY = 1
) (
  input  logic              clk,
  input  logic              res,
  input  logic              rdy,
  input  logic              start,
  input  logic [3:0]        mode,
  input  logic [7:0]        data_in,
  input  logic [7:0]        index_x,
  input  logic [7:0]        index_y,
  output logic [1:0]        address_select,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              pc_enable,
  output logic              busy,
  output logic [ADDR_W-1:0] ea,
  output logic              ea_imm,
  output logic              ea_valid,
  output logic              page_cross,
  output logic              err
);

  logic [3:0]  state, nxt;
  logic [3:0]  mode_q, mode_n;
  logic [7:0]  lo, lo_n;
  logic [7:0]  hi, hi_n;
  logic [7:0]  ba_q, ba_n;
  logic [15:0] ea_q, ea_n;
  logic [1:0]  asel_q, asel_n;
  logic        imm_q, imm_n;
  logic        pcr_q, pcr_n;
  logic        pce_q, pce_n;
  logic        busy_q, busy_n;
  logic        vld_q, vld_n;
  logic        err_q, err_n;
`ifdef ADR_INDIRECT_EN
  logic [7:0]  ptr, ptr_n;
`endif

  logic [15:0] add_base, add_sum;
  logic [7:0]  add_idx;
  logic        add_zp, add_c;
  logic        pen;

  ea_index_adder u_add (
    .base  (add_base),
    .idx   (add_idx),
    .zp    (add_zp),
    .sum   (add_sum),
    .carry (add_c)
  );

  assign pen = add_c && (PAGE_PENALTY != 0);

  function automatic logic mode_ok(input logic [3:0] m);
`ifdef ADR_INDIRECT_EN
    return m <= ADRM_IND_Y;
`else
    return m <= ADRM_ABS_Y;
`endif
  endfunction

  always_comb begin
    nxt      = state;
    mode_n   = mode_q;
    lo_n     = lo;
    hi_n     = hi;
    ba_n     = ba_q;
    ea_n     = ea_q;
    imm_n    = imm_q;
    pcr_n    = pcr_q;
    err_n    = 1'b0;
`ifdef ADR_INDIRECT_EN
    ptr_n    = ptr;
`endif
    add_base = {hi, lo};
    add_idx  = 8'h00;
    add_zp   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (mode == ADRM_IMPL) begin
            nxt    = S_DONE;
            mode_n = mode;
            ea_n   = 16'h0000;
            imm_n  = 1'b0;
            pcr_n  = 1'b0;
          end else if (mode_ok(mode)) begin
            nxt    = S_OP_LO;
            mode_n = mode;
          end else begin
            err_n  = 1'b1;
          end
        end
      end
      S_OP_LO: begin
        nxt = is_abs(mode_q) ? S_OP_HI : S_CALC;
      end
      S_OP_HI: begin
        lo_n = data_in;
        nxt  = S_CALC;
      end
      S_CALC: begin
        // second operand byte is the high byte only for absolute modes
        if (is_abs(mode_q)) begin
          hi_n     = data_in;
          add_base = {data_in, lo};
        end else begin
          lo_n     = data_in;
          hi_n     = 8'h00;
          add_base = {8'h00, data_in};
        end
        add_zp = is_zp(mode_q);
        if (uses_x(mode_q)) begin
          add_idx = index_x;
        end else if (uses_y(mode_q)) begin
          add_idx = index_y;
        end
`ifdef ADR_INDIRECT_EN
        if (mode_q == ADRM_IND_X || mode_q == ADRM_IND_Y) begin
          ptr_n = add_sum[7:0];
          ba_n  = add_sum[7:0];
          nxt   = S_PTR_LO;
        end else
`endif
        begin
          ea_n  = add_sum;
          imm_n = (mode_q == ADRM_IMM);
          pcr_n = add_c;
          nxt   = pen ? S_FIX : S_DONE;
        end
      end
`ifdef ADR_INDIRECT_EN
      S_PTR_LO: begin
        // pointer high byte wraps inside page 0
        ba_n = ptr + 8'd1;
        nxt  = S_PTR_HI;
      end
      S_PTR_HI: begin
        lo_n = data_in;
        nxt  = S_PTR_CALC;
      end
      S_PTR_CALC: begin
        hi_n     = data_in;
        add_base = {data_in, lo};
        if (mode_q == ADRM_IND_Y) begin
          add_idx = index_y;
        end
        ea_n  = add_sum;
        imm_n = 1'b0;
        pcr_n = add_c;
        nxt   = pen ? S_FIX : S_DONE;
      end
`endif
      S_FIX: begin
        nxt = S_DONE;
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
    // outputs are registered from the state being entered
    pce_n  = (nxt == S_OP_LO) || (nxt == S_OP_HI);
    asel_n = ((nxt == S_PTR_LO) || (nxt == S_PTR_HI)) ?
             ADSEL_BUS : ADSEL_PC;
    busy_n = (nxt != S_IDLE);
    vld_n  = (nxt == S_DONE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= S_IDLE;
      mode_q <= 4'd0;
      lo     <= 8'h00;
      hi     <= 8'h00;
      ba_q   <= 8'h00;
      ea_q   <= 16'h0000;
      asel_q <= ADSEL_PC;
      imm_q  <= 1'b0;
      pcr_q  <= 1'b0;
      pce_q  <= 1'b0;
      busy_q <= 1'b0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
`ifdef ADR_INDIRECT_EN
      ptr    <= 8'h00;
`endif
    end else if (rdy) begin
      state  <= nxt;
      mode_q <= mode_n;
      lo     <= lo_n;
      hi     <= hi_n;
      ba_q   <= ba_n;
      ea_q   <= ea_n;
      asel_q <= asel_n;
      imm_q  <= imm_n;
      pcr_q  <= pcr_n;
      pce_q  <= pce_n;
      busy_q <= busy_n;
      vld_q  <= vld_n;
      err_q  <= err_n;
`ifdef ADR_INDIRECT_EN
      ptr    <= ptr_n;
`endif
    end
  end

  // a frozen cycle must never advance the PC
  assign pc_enable      = pce_q & rdy;
  assign address_select = asel_q;
  assign bus_addr       = ADDR_W'(ba_q);
  assign busy           = busy_q;
  assign ea             = ADDR_W'(ea_q);
  assign ea_imm         = imm_q;
  assign ea_valid       = vld_q;
  assign page_cross     = pcr_q;
  assign err            = err_q;

endmodule

// File: tb/tb_operand_address_sequencer.sv
// Directed bench for operand_address_sequencer with a small
// memory model; second instance runs with PAGE_PENALTY=0.
module tb_operand_address_sequencer;

  logic        clk = 1'b0;
  logic        res = 1'b0;
  logic        rdy = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [7:0]  data_in;
  logic [7:0]  index_x = 8'h00;
  logic [7:0]  index_y = 8'h00;

  logic [1:0]  address_select;
  logic [15:0] bus_addr;
  logic        pc_enable, busy, ea_imm, ea_valid;
  logic        page_cross, err;
  logic [15:0] ea;

  logic [1:0]  asel0;
  logic [19:0] bus_addr0, ea0;
  logic        pce0, busy0, imm0, vld0, pcr0, err0;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:255];
  logic [15:0] pc;

  always #5 clk = ~clk;

  operand_address_sequencer #(
    .ADDR_W(16), .PAGE_PENALTY(1)
  ) dut (
    .clk(clk), .res(res), .rdy(rdy), .start(start),
    .mode(mode), .data_in(data_in),
    .index_x(index_x), .index_y(index_y),
    .address_select(address_select), .bus_addr(bus_addr),
    .pc_enable(pc_enable), .busy(busy), .ea(ea),
    .ea_imm(ea_imm), .ea_valid(ea_valid),
    .page_cross(page_cross), .err(err)
  );

  operand_address_sequencer #(
    .ADDR_W(20), .PAGE_PENALTY(0)
  ) dut0 (
    .clk(clk), .res(res), .rdy(rdy), .start(start),
    .mode(mode), .data_in(data_in),
    .index_x(index_x), .index_y(index_y),
    .address_select(asel0), .bus_addr(bus_addr0),
    .pc_enable(pce0), .busy(busy0), .ea(ea0),
    .ea_imm(imm0), .ea_valid(vld0),
    .page_cross(pcr0), .err(err0)
  );

  // read data for the byte addressed in one cycle appears in the next
  always @(posedge clk or negedge res) begin
    if (!res) begin
      pc      <= 16'h0040;
      data_in <= 8'h00;
    end else if (rdy) begin
      data_in <= mem[(address_select == 2'd1) ?
                     bus_addr[7:0] : pc[7:0]];
      if (pc_enable) pc <= pc + 16'd1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic run(input logic [3:0] m,
                     input logic [7:0] b0, b1,
                     input int fz_at, fz_len,
                     output int lat, pce, frz, nbus,
                     output logic [15:0] ba0, ba1,
                     output int lat0);
    mem[pc[7:0]] = b0;
    mem[pc[7:0] + 8'd1] = b1;
    lat = 0; pce = 0; frz = 0; nbus = 0; lat0 = 0;
    ba0 = 16'h0; ba1 = 16'h0;
    @(posedge clk); #1;
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    forever begin
      lat++;
      rdy = !(lat >= fz_at && lat < fz_at + fz_len);
      #1;
      if (pc_enable) begin
        pce++;
        if (!rdy) frz++;
      end
      if (address_select == 2'd1) begin
        if (nbus == 0) ba0 = bus_addr;
        else if (nbus == 1) ba1 = bus_addr;
        nbus++;
      end
      if (vld0 && lat0 == 0) lat0 = lat;
      if (ea_valid || lat >= 30) break;
      @(posedge clk); #1;
    end
    rdy = 1'b1;
  endtask

  task automatic illegal(input logic [3:0] m, input string tag);
    @(posedge clk); #1;
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_bus"},
          32'({address_select, pc_enable}), 32'd0);
    @(posedge clk); #1;
    check({tag, "_errpulse"}, 32'(err), 32'd0);
  endtask

  int lat, pce, frz, nbus, lat0;
  logic [15:0] ba0, ba1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
    #3;
    check("rst_flags",
          32'({address_select, pc_enable, busy, ea_valid,
               err, page_cross, ea_imm}), 32'd0);
    check("rst_ea", 32'(ea), 32'd0);
    check("rst_bus", 32'(bus_addr), 32'd0);
    @(posedge clk); #1;
    res = 1'b1;

    index_x = 8'h10;
    run(4'd3, 8'hF8, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("zpgx_ea", 32'(ea), 32'h0008);
    check("zpgx_pcross", 32'(page_cross), 32'd0);
    check("zpgx_lat", 32'(lat), 32'd3);
    check("zpgx_pce", 32'(pce), 32'd1);

    run(4'd1, 8'h5A, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("imm_ea", 32'(ea), 32'h005A);
    check("imm_flag", 32'(ea_imm), 32'd1);
    check("imm_lat", 32'(lat), 32'd3);

    index_y = 8'h05;
    run(4'd4, 8'h20, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("zpgy_ea", 32'(ea), 32'h0025);
    check("zpgy_imm", 32'(ea_imm), 32'd0);

    run(4'd5, 8'h34, 8'h12, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("abs_ea", 32'(ea), 32'h1234);
    check("abs_lat", 32'(lat), 32'd4);
    check("abs_pce", 32'(pce), 32'd2);

    run(4'd6, 8'h00, 8'h10, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("absx_ea", 32'(ea), 32'h1010);
    check("absx_pcross", 32'(page_cross), 32'd0);
    check("absx_lat", 32'(lat), 32'd4);

    index_y = 8'h20;
    run(4'd7, 8'hF0, 8'h12, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("absy_ea", 32'(ea), 32'h1310);
    check("absy_pcross", 32'(page_cross), 32'd1);
    check("absy_lat", 32'(lat), 32'd5);
    check("absy_pce", 32'(pce), 32'd2);
    check("absy_nopen_lat", 32'(lat0), 32'd4);
    check("absy_nopen_ea", 32'(ea0), 32'h01310);
    check("absy_nopen_pcross", 32'(pcr0), 32'd1);

    run(4'd5, 8'h34, 8'h12, 2, 3,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("frz_ea", 32'(ea), 32'h1234);
    check("frz_lat", 32'(lat), 32'd7);
    check("frz_pce_off", 32'(frz), 32'd0);
    check("frz_pce", 32'(pce), 32'd2);

    run(4'd0, 8'h00, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("impl_ea", 32'(ea), 32'h0000);
    check("impl_lat", 32'(lat), 32'd1);

    illegal(4'd12, "ill12");

`ifdef ADR_INDIRECT_EN
    index_x = 8'h10;
    mem[8'h30] = 8'h78;
    mem[8'h31] = 8'h56;
    run(4'd8, 8'h20, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("indx_ea", 32'(ea), 32'h5678);
    check("indx_ba0", 32'(ba0), 32'h0030);
    check("indx_ba1", 32'(ba1), 32'h0031);
    check("indx_lat", 32'(lat), 32'd6);

    index_y = 8'h01;
    mem[8'hFF] = 8'h34;
    mem[8'h00] = 8'h12;
    run(4'd9, 8'hFF, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("indy_ea", 32'(ea), 32'h1235);
    check("indy_ba0", 32'(ba0), 32'h00FF);
    check("indy_ba1", 32'(ba1), 32'h0000);
    check("indy_nbus", 32'(nbus), 32'd2);
    check("indy_pcross", 32'(page_cross), 32'd0);
    check("indy_lat", 32'(lat), 32'd6);
    check("indy_pce", 32'(pce), 32'd1);
`else
    illegal(4'd8, "ill8");
    illegal(4'd9, "ill9");
`endif

    mem[pc[7:0]] = 8'hFF;
    mem[pc[7:0] + 8'd1] = 8'h12;
    @(posedge clk); #1;
`ifdef ADR_INDIRECT_EN
    mode = 4'd9;
`else
    mode = 4'd5;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
`ifdef ADR_INDIRECT_EN
    repeat (3) begin @(posedge clk); #1; end
    check("prerst_asel", 32'(address_select), 32'd1);
`else
    @(posedge clk); #1;
    check("prerst_pce", 32'(pc_enable), 32'd1);
`endif
    res = 1'b0;
    #1;
    check("arst_flags",
          32'({address_select, pc_enable, busy, ea_valid,
               err, page_cross, ea_imm}), 32'd0);
    check("arst_ea", 32'(ea), 32'd0);
    check("arst_bus", 32'(bus_addr), 32'd0);
    @(posedge clk); #1;
    check("arst_novalid", 32'(ea_valid), 32'd0);
    res = 1'b1;
    run(4'd0, 8'h00, 8'h00, 0, 0,
        lat, pce, frz, nbus, ba0, ba1, lat0);
    check("post_impl_lat", 32'(lat), 32'd1);
    check("post_impl_ea", 32'(ea), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
